// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams one operand nibble per clock through a single 4-bit
// carry-select slice, ripples the carry through a register and reassembles the sum.

module csa (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] sum0, sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + 5'd1;
  assign s    = ci ? sum1[3:0] : sum0[3:0];
  assign co   = ci ? sum1[4] : sum0[4];
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int unsigned NIBBLES  = WIDTH / 4;
  localparam int unsigned CntWidth = $clog2(NIBBLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  // Holds only the nibbles already produced; the current slice output completes the word.
  logic [WIDTH-5:0]      sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]      sum_next;
  logic                  carry_q, carry_d;
  logic                  a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]      s_q, s_d;
  logic                  co_q, co_d, ovf_q, ovf_d;
  logic [3:0]            slice_s;
  logic                  slice_co;

  csa u_csa (
    .a  (a_sh_q[3:0]),
    .b  (b_sh_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign sum_next = {slice_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = ci;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_sh_d = sum_next[WIDTH-1:4];
        carry_d  = slice_co;
        a_sh_d   = {4'b0000, a_sh_q[WIDTH-1:4]};
        b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
        cnt_d    = cnt_q + CntWidth'(1);
        if (cnt_q == CntWidth'(NIBBLES - 1)) begin
          s_d     = sum_next;
          co_d    = slice_co;
          ovf_d   = (a_msb_q == b_msb_q) && (slice_s[3] != a_msb_q);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases and handshake scenarios on a 16-bit
// instance, plus randomized scoreboard sweeps on 16- and 32-bit instances.

module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ci16, ov16, or16, co16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, ci32, ov32, or32, co32, ovf32;
  logic [31:0] a32, b32, s32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .ci(ci16),
    .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16), .ovf(ovf16)
  );

  nibble_serial_adder #(.WIDTH(32)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .ci(ci32),
    .out_valid(ov32), .out_ready(or32), .s(s32), .co(co32), .ovf(ovf32)
  );

  // Reference: returns {ovf, co, s} from plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input longint x, input longint y, input logic c,
                                        input int w);
    longint half, full, sx, sy, ssum;
    logic [63:0] fu;
    half = longint'(1) << (w - 1);
    full = x + y + longint'(c);
    sx   = (x >= half) ? x - 2 * half : x;
    sy   = (y >= half) ? y - 2 * half : y;
    ssum = sx + sy + longint'(c);
    fu   = full % (2 * half);
    model        = '0;
    model[31:0]  = fu[31:0];
    model[32]    = (full >= 2 * half);
    model[33]    = (ssum >= half) || (ssum < -half);
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0; ci16 = 0;
    iv32 = 0; or32 = 0; a32 = '0; b32 = '0; ci32 = 0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({ir16, ov16, s16, co16, ovf16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got ir=%b ov=%b s=%h co=%b ovf=%b, want 1 0 0000 0 0",
               ir16, ov16, s16, co16, ovf16);
    end
    checks++;
    if ({ir32, ov32, s32, co32, ovf32} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset32: got ir=%b ov=%b s=%h co=%b ovf=%b, want 1 0 0 0 0",
               ir32, ov32, s32, co32, ovf32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ta[4], tb[4], ts[4];
    logic        tc[4], tco[4], tov[4];
    int          lat;
    ta  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
    tb  = '{16'h4321, 16'h0001, 16'h0001, 16'h8000};
    tc  = '{1'b1, 1'b0, 1'b0, 1'b0};
    ts  = '{16'h5556, 16'h0000, 16'h8000, 16'h0000};
    tco = '{1'b0, 1'b1, 1'b0, 1'b1};
    tov = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a16 = ta[i]; b16 = tb[i]; ci16 = tc[i]; iv16 = 1; or16 = 1;
      lat = 0;
      do begin
        @(negedge clk);
        iv16 = 0;
        lat++;
      end while (!ov16 && lat < 20);
      checks++;
      if (lat - 1 != 4) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d edges, want 4", i, lat - 1);
      end
      checks++;
      if ({s16, co16, ovf16} !== {ts[i], tco[i], tov[i]}) begin
        errors++;
        $display("FAIL directed[%0d]: got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                 i, s16, co16, ovf16, ts[i], tco[i], tov[i]);
      end
      @(negedge clk);
      checks++;
      if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
        errors++;
        $display("FAIL directed_release[%0d]: got ov=%b ir=%b, want 0 1", i, ov16, ir16);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp;
    int          n;
    a16 = 16'h3A5C; b16 = 16'h1111; ci16 = 0; iv16 = 1; or16 = 0;
    exp = model(longint'(a16), longint'(b16), ci16, 16);
    n = 0;
    do begin
      @(negedge clk);
      iv16 = 0;
      n++;
    end while (!ov16 && n < 20);
    checks++;
    if (!ov16) begin
      errors++;
      $display("FAIL bp_timeout: got out_valid=%b, want 1", ov16);
    end
    for (int i = 0; i < 5; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); iv16 = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({ov16, ir16, ovf16, co16, s16} !== {1'b1, 1'b0, exp[33:32], exp[15:0]}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b s=%h co=%b ovf=%b, want 1 0 %h %b %b",
                 i, ov16, ir16, s16, co16, ovf16, exp[15:0], exp[32], exp[33]);
      end
    end
    iv16 = 0; or16 = 1;
    @(negedge clk);
    checks++;
    if ({ov16, ir16, s16} !== {1'b0, 1'b1, exp[15:0]}) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b s=%h, want 0 1 %h", ov16, ir16, s16, exp[15:0]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    a16 = 16'hABCD; b16 = 16'h1357; ci16 = 1; iv16 = 1; or16 = 1;
    @(negedge clk);
    iv16 = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir16, ov16, s16, co16, ovf16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got ir=%b ov=%b s=%h co=%b ovf=%b, want 1 0 0000 0 0",
               ir16, ov16, s16, co16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ov16 !== 1'b0) begin
        errors++;
        $display("FAIL aborted_result[%0d]: got out_valid=%b, want 0", i, ov16);
      end
    end
    a16 = 16'h0F0F; b16 = 16'hF0F0; ci16 = 1; iv16 = 1;
    n = 0;
    do begin
      @(negedge clk);
      iv16 = 0;
      n++;
    end while (!ov16 && n < 20);
    checks++;
    if ({ov16, s16, co16, ovf16} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_op: got ov=%b s=%h co=%b ovf=%b, want 1 0000 1 0",
               ov16, s16, co16, ovf16);
    end
    @(negedge clk);
  endtask

  task automatic test_random16(input int n);
    logic [33:0] q[$];
    logic [33:0] exp;
    int          sent = 0, got = 0, cyc = 0;
    logic        pend = 0;
    iv16 = 0; or16 = 0;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      or16 = ($urandom_range(0, 3) != 0);
      if (!pend && sent < n && $urandom_range(0, 2) == 0) begin
        a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); pend = 1;
      end
      iv16 = pend;
      if (pend && ir16) begin
        q.push_back(model(longint'(a16), longint'(b16), ci16, 16));
        sent++;
        pend = 0;
      end
      if (ov16 && or16) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand16_extra: got unexpected result s=%h, want none", s16);
        end else begin
          exp = q.pop_front();
          if ({ovf16, co16, s16} !== {exp[33:32], exp[15:0]}) begin
            errors++;
            $display("FAIL rand16[%0d]: got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                     got, s16, co16, ovf16, exp[15:0], exp[32], exp[33]);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != n || q.size() != 0) begin
      errors++;
      $display("FAIL rand16_count: got %0d results (%0d queued), want %0d", got, q.size(), n);
    end
    iv16 = 0; or16 = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random32(input int n);
    logic [33:0] q[$];
    logic [33:0] exp;
    int          sent = 0, got = 0, cyc = 0;
    logic        pend = 0;
    iv32 = 0; or32 = 0;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      or32 = ($urandom_range(0, 3) != 0);
      if (!pend && sent < n && $urandom_range(0, 2) == 0) begin
        a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); pend = 1;
      end
      iv32 = pend;
      if (pend && ir32) begin
        q.push_back(model(longint'(a32), longint'(b32), ci32, 32));
        sent++;
        pend = 0;
      end
      if (ov32 && or32) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand32_extra: got unexpected result s=%h, want none", s32);
        end else begin
          exp = q.pop_front();
          if ({ovf32, co32, s32} !== exp) begin
            errors++;
            $display("FAIL rand32[%0d]: got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                     got, s32, co32, ovf32, exp[31:0], exp[32], exp[33]);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != n || q.size() != 0) begin
      errors++;
      $display("FAIL rand32_count: got %0d results (%0d queued), want %0d", got, q.size(), n);
    end
    iv32 = 0; or32 = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random16(500);
    test_random32(500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder. Adds two WIDTH-bit operands plus a carry-in, 4 bits per clock.
- Drives a single instance of the team's 4-bit carry-select adder slice, `csa` (ports a[3:0], b[3:0], ci, s[3:0], co).
- Sits directly upstream of that slice: it sequences operand nibbles into the slice, registers the ripple carry between cycles, and reassembles the sum.
- Trades latency for area wherever a full-width adder is too large. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and >= 8.
- NIBBLES, WIDTH/4, derived local constant: number of slice iterations per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- ci  input  1  carry-in, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum, registered.
- co  output  1  carry-out of bit WIDTH-1, registered.
- ovf  output  1  signed (two's complement) overflow, registered.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state=IDLE, in_ready=1, out_valid=0, s=0, co=0, ovf=0.
  - Internal operand registers, carry register and counter are all 0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - Accept on in_valid&&in_ready.
  - Latch a->a_sh, b->b_sh, ci->carry_r, a[WIDTH-1]->a_msb, b[WIDTH-1]->b_msb.
  - cnt=0; go to RUN.
  - Inputs are ignored when in_valid=0.
- RUN, each cycle:
  - Slice inputs: a=a_sh[3:0], b=b_sh[3:0], ci=carry_r.
  - Update sum_sh <= {slice.s, sum_sh[WIDTH-1:4]} (LSB nibble enters first and ends lowest).
  - carry_r <= slice.co.
  - a_sh and b_sh shift right by 4, zero-filled.
  - cnt <= cnt+1.
  - On the cycle where cnt==NIBBLES-1, also load outputs:
    - s <= final sum_sh value (including this cycle's nibble).
    - co <= slice.co.
    - ovf <= (a_msb==b_msb) && (slice.s[3] != a_msb).
    - Go to DONE.
- Latency and throughput:
  - Exactly NIBBLES RUN cycles.
  - out_valid rises NIBBLES clock edges after the accepting edge.
  - Upstream input changes during RUN/DONE have no effect.
- DONE:
  - s, co and ovf are held stable while out_valid=1 && out_ready=0 (backpressure unbounded).
  - On out_ready=1: out_valid drops next edge, state goes to IDLE. s/co/ovf keep their last value until the next load.
- Back-to-back operations: one operation per NIBBLES+2 cycles (accept edge, NIBBLES RUN edges, DONE handshake edge). No accept is possible in DONE.
- Arithmetic:
  - Result is exact modulo 2^WIDTH: {co,s} = a+b+ci.
  - Carry chains across nibbles only through carry_r; the slice is purely combinational.
- Counter: width is $clog2(NIBBLES). It must not wrap before the exit compare.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, ci=1, out_ready=1 -> out_valid exactly 4 edges after accept; s=0x5556, co=0, ovf=0.
- a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Carry must ripple through all 4 nibbles via carry_r.
- a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, co=0, ovf=1. Also a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and change a/b/in_valid meanwhile -> s/co/ovf stable, in_ready=0. Release -> IDLE next edge, in_ready=1.
- Assert rst_n=0 asynchronously after 2 RUN cycles -> outputs immediately 0, in_ready=1. The next operation (0x0F0F+0xF0F0, ci=1 -> s=0x0000, co=1) is correct, with no residual carry.
- Random sweep, 1000 ops, random in_valid/out_ready gaps, WIDTH=16 and WIDTH=32 -> every result matches the a+b+ci reference model, in order, none dropped or duplicated.
